// File: rtl/pe_array_feeder.sv
// Sequences chunked activation/weight streams into a PE array and returns one partial sum per job.
// Optional macro FEEDER_STALL_CNT_EN adds o_Stall_Cnt, a saturating count of STREAM bubble cycles.
`ifndef BITS_ACT
`define BITS_ACT 8
`endif
`ifndef BITS_WEIGHT
`define BITS_WEIGHT 8
`endif
`ifndef PE_ROW
`define PE_ROW 4
`endif
`ifndef N_BIAS
`define N_BIAS 16
`endif
`ifndef BITS_PSUM
`define BITS_PSUM 32
`endif

module pe_array_feeder #(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  i_Start,
    input  logic [7:0]                            i_Num_Chunk,
    input  logic [3:0]                            i_Precision,
    input  logic [`N_BIAS-1:0]                    i_Bias,
    input  logic                                  i_Data_vld,
    output logic                                  o_Data_rdy,
    input  logic [`BITS_ACT*`PE_ROW-1:0]          i_Act_Data,
    input  logic [`BITS_WEIGHT*`PE_ROW-1:0]       i_Weight_Data,
    output logic [`BITS_ACT*`PE_ROW-1:0]          o_Act,
    output logic [`BITS_WEIGHT*`PE_ROW-1:0]       o_Weight,
    output logic [3:0]                            o_Precision,
    output logic [`N_BIAS-1:0]                    o_Bias,
    output logic                                  o_Sel_Bias,
    output logic                                  o_Flush,
    output logic                                  o_core_vld,
    input  logic signed [`BITS_PSUM-1:0]          i_Psum,
    input  logic                                  i_Done,
    output logic signed [`BITS_PSUM-1:0]          o_Result,
    output logic                                  o_Result_vld,
    input  logic                                  i_Result_rdy,
    output logic                                  o_Busy
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                           o_Stall_Cnt
`endif
);

    localparam int unsigned CHUNK_W = 8;
    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t               r_state;
    logic [CHUNK_W-1:0]   r_chunk_left;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_first;

    // Array completion is not needed: result timing comes from the fixed pipeline latency.
    logic w_unused_done;
    assign w_unused_done = i_Done;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_chunk_left <= '0;
            r_drain_cnt  <= '0;
            r_first      <= 1'b0;
            o_Data_rdy   <= 1'b0;
            o_Act        <= '0;
            o_Weight     <= '0;
            o_Precision  <= 4'b0000;
            o_Bias       <= '0;
            o_Sel_Bias   <= 1'b0;
            o_Flush      <= 1'b0;
            o_core_vld   <= 1'b0;
            o_Result     <= '0;
            o_Result_vld <= 1'b0;
            o_Busy       <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
            o_Stall_Cnt  <= 16'd0;
`endif
        end else begin
            // Array-side strobes and data are zero unless a chunk moves this cycle.
            o_core_vld <= 1'b0;
            o_Sel_Bias <= 1'b0;
            o_Act      <= '0;
            o_Weight   <= '0;
            o_Flush    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_state      <= S_STREAM;
                        r_chunk_left <= (i_Num_Chunk == CHUNK_W'(0)) ? CHUNK_W'(1) : i_Num_Chunk;
                        r_first      <= 1'b1;
                        o_Precision  <= i_Precision;
                        o_Bias       <= i_Bias;
                        o_Data_rdy   <= 1'b1;
                        o_Busy       <= 1'b1;
`ifdef FEEDER_STALL_CNT_EN
                        o_Stall_Cnt  <= 16'd0;
`endif
                    end
                end

                S_STREAM: begin
                    if (i_Data_vld) begin
                        o_Act        <= i_Act_Data;
                        o_Weight     <= i_Weight_Data;
                        o_core_vld   <= 1'b1;
                        o_Sel_Bias   <= r_first;
                        r_first      <= 1'b0;
                        r_chunk_left <= r_chunk_left - CHUNK_W'(1);
                        if (r_chunk_left == CHUNK_W'(1)) begin
                            r_state     <= S_DRAIN;
                            o_Data_rdy  <= 1'b0;
                            r_drain_cnt <= DRAIN_W'(PIPE_LAT);
                        end
                    end
`ifdef FEEDER_STALL_CNT_EN
                    else if (o_Stall_Cnt != 16'hFFFF) begin
                        o_Stall_Cnt <= o_Stall_Cnt + 16'd1;
                    end
`endif
                end

                // Capture lands PIPE_LAT edges after the last chunk was issued.
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(1)) begin
                        o_Result     <= i_Psum;
                        o_Result_vld <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end

                S_HOLD: begin
                    if (i_Result_rdy) begin
                        o_Result_vld <= 1'b0;
                        o_Flush      <= 1'b1;
                        o_Busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
